// File: rtl/csi2_pkg.sv
// Shared constants and helpers for the CSI-2 packet parser: data types,
// the CRC-16 (0x8408 reflected) byte step and the 6-bit header ECC.
package csi2_pkg;

  localparam logic [5:0]  DT_FS        = 6'h00;
  localparam logic [5:0]  DT_FE        = 6'h01;
  localparam logic [5:0]  DT_LS        = 6'h02;
  localparam logic [5:0]  DT_LE        = 6'h03;
  localparam logic [5:0]  DT_SHORT_MAX = 6'h0F;

  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Each parity bit covers a fixed subset of the 24 header data bits.
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/csi2_crc16_acc.sv
// Running CRC-16 over up to four bytes per cycle; enabled bytes are folded
// from byte0 upward. crc_nxt exposes the value including the current word.
module csi2_crc16_acc
  import csi2_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [3:0]  be,
  output logic [15:0] crc,
  output logic [15:0] crc_nxt
);

  always_comb begin
    crc_nxt = crc;
    for (int i = 0; i < 4; i++)
      if (be[i]) crc_nxt = crc16_byte(crc_nxt, data[8*i +: 8]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     crc <= '0;
    else if (clr)  crc <= '0;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc_nxt;
  end

endmodule

// File: rtl/csi2_pkt_parser.sv
// CSI-2 low-level packet parser: header decode/ECC check, short-packet events,
// long-packet payload stream with CRC-16 footer stripping and checking.
//
// state     | meaning
// S_IDLE    | waiting for a packet header
// S_PAYLOAD | forwarding long-packet payload bytes
// S_CRC     | collecting the remaining CRC footer bytes
// S_DISCARD | header failed ECC; dropping words until the next header
module csi2_pkt_parser
  import csi2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] merging_dat,
  input  logic        merging_valid,
  input  logic        pkt_sof,
  output logic        sp_vld,
  output logic [1:0]  sp_vc,
  output logic [5:0]  sp_dt,
  output logic [15:0] sp_data,
  output logic        lp_vld,
  output logic [31:0] lp_data,
  output logic [3:0]  lp_be,
  output logic        lp_sof,
  output logic        lp_eof,
  output logic [1:0]  lp_vc,
  output logic [5:0]  lp_dt,
  output logic [15:0] lp_wc,
  output logic        ecc_err,
  output logic        crc_err,
  output logic        pkt_abort
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_CRC     = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    state;
  logic [15:0]   rem;
  logic [1:0]    crc_left;
  logic [7:0]    crc_lo;
  logic [TW-1:0] idle_cnt;

  logic          hdr, ecc_ok, is_short, in_pkt, timeout;
  logic          acc_init, acc_en;
  logic [2:0]    n;
  logic [3:0]    be;
  logic [15:0]   rem_nxt, crc_in, crc_run, crc_nxt;

  always_comb begin
    hdr      = merging_valid & pkt_sof;
    ecc_ok   = ecc6(merging_dat[23:0]) == merging_dat[29:24];
    is_short = merging_dat[5:0] <= DT_SHORT_MAX;
    in_pkt   = (state == S_PAYLOAD) || (state == S_CRC);
    n        = (rem >= 16'd4) ? 3'd4 : rem[2:0];
    case (n)
      3'd1:    be = 4'b0001;
      3'd2:    be = 4'b0011;
      3'd3:    be = 4'b0111;
      3'd4:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    rem_nxt  = rem - {13'd0, n};
    // Footer bytes trailing the last payload byte, low byte first.
    crc_in   = 16'(merging_dat >> {n, 3'b000});
    timeout  = in_pkt & ~merging_valid & (idle_cnt == TW'(1));
    acc_init = hdr & ecc_ok & ~is_short;
    acc_en   = merging_valid & ~pkt_sof & (state == S_PAYLOAD);
  end

  csi2_crc16_acc u_crc (
    .clk     (clk),
    .reset   (reset),
    .init    (acc_init),
    .clr     (timeout),
    .en      (acc_en),
    .data    (merging_dat),
    .be      (be),
    .crc     (crc_run),
    .crc_nxt (crc_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;   rem <= '0;      crc_left <= '0;  crc_lo <= '0;
      idle_cnt <= '0;    sp_vld <= 1'b0; sp_vc <= '0;     sp_dt <= '0;
      sp_data <= '0;     lp_vld <= 1'b0; lp_data <= '0;   lp_be <= '0;
      lp_sof <= 1'b0;    lp_eof <= 1'b0; lp_vc <= '0;     lp_dt <= '0;
      lp_wc <= '0;       ecc_err <= 1'b0; crc_err <= 1'b0; pkt_abort <= 1'b0;
    end else begin
      sp_vld <= 1'b0;  lp_vld <= 1'b0;  lp_sof <= 1'b0;    lp_eof <= 1'b0;
      ecc_err <= 1'b0; crc_err <= 1'b0; pkt_abort <= 1'b0;

      if (in_pkt) begin
        if (merging_valid)       idle_cnt <= TW'(TIMEOUT_CYC);
        else if (idle_cnt != '0) idle_cnt <= idle_cnt - TW'(1);
      end

      if (hdr) begin
        pkt_abort <= in_pkt;
        if (!ecc_ok) begin
          ecc_err <= 1'b1;
          state   <= S_DISCARD;
        end else if (is_short) begin
          sp_vld  <= 1'b1;
          sp_vc   <= merging_dat[7:6];
          sp_dt   <= merging_dat[5:0];
          sp_data <= merging_dat[23:8];
          state   <= S_IDLE;
        end else begin
          lp_vc    <= merging_dat[7:6];
          lp_dt    <= merging_dat[5:0];
          lp_wc    <= merging_dat[23:8];
          rem      <= merging_dat[23:8];
          idle_cnt <= TW'(TIMEOUT_CYC);
          crc_left <= 2'd2;
          state    <= (merging_dat[23:8] != 16'd0) ? S_PAYLOAD : S_CRC;
        end
      end else if (timeout) begin
        pkt_abort <= 1'b1;
        state     <= S_IDLE;
      end else if (merging_valid) begin
        case (state)
          S_PAYLOAD: begin
            lp_vld  <= 1'b1;
            lp_data <= merging_dat;
            lp_be   <= be;
            lp_sof  <= (rem == lp_wc);
            rem     <= rem_nxt;
            if (rem_nxt == 16'd0) begin
              lp_eof <= 1'b1;
              if (n == 3'd4) begin
                crc_left <= 2'd2;
                state    <= S_CRC;
              end else if (n == 3'd3) begin
                crc_lo   <= merging_dat[31:24];
                crc_left <= 2'd1;
                state    <= S_CRC;
              end else begin
                crc_err <= (crc_in != crc_nxt);
                state   <= S_IDLE;
              end
            end
          end
          S_CRC: begin
            if (crc_left == 2'd2) crc_err <= (merging_dat[15:0] != crc_run);
            else                  crc_err <= ({merging_dat[7:0], crc_lo} != crc_run);
            state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csi2_pkt_parser.sv
// Directed bench for csi2_pkt_parser: short/long packets, CRC and ECC errors,
// aborts by new header and by idle timeout, and 1-lane word cadence.
module tb_csi2_pkt_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] merging_dat;
  logic        merging_valid;
  logic        pkt_sof;
  logic        sp_vld, lp_vld, lp_sof, lp_eof, ecc_err, crc_err, pkt_abort;
  logic [1:0]  sp_vc, lp_vc;
  logic [5:0]  sp_dt, lp_dt;
  logic [15:0] sp_data, lp_wc;
  logic [31:0] lp_data;
  logic [3:0]  lp_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csi2_pkt_parser #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .reset(reset), .merging_dat(merging_dat),
    .merging_valid(merging_valid), .pkt_sof(pkt_sof),
    .sp_vld(sp_vld), .sp_vc(sp_vc), .sp_dt(sp_dt), .sp_data(sp_data),
    .lp_vld(lp_vld), .lp_data(lp_data), .lp_be(lp_be), .lp_sof(lp_sof),
    .lp_eof(lp_eof), .lp_vc(lp_vc), .lp_dt(lp_dt), .lp_wc(lp_wc),
    .ecc_err(ecc_err), .crc_err(crc_err), .pkt_abort(pkt_abort)
  );

  // Reference CRC using the byte-wise table-free formulation of the 0x8408 CRC.
  function automatic logic [15:0] crc_ref(input logic [63:0] bytes, input int len);
    logic [15:0] c;
    logic [7:0]  d;
    c = 16'hFFFF;
    for (int i = 0; i < len; i++) begin
      d = bytes[8*i +: 8] ^ c[7:0];
      d = d ^ {d[3:0], 4'b0000};
      c = {d, c[15:8]} ^ {12'h000, d[7:4]} ^ {5'b00000, d, 3'b000};
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic s, input logic [31:0] d);
    @(negedge clk);
    merging_valid = v;
    pkt_sof       = s;
    merging_dat   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0);
  endtask

  // RAW8 VC1 WC=6 packet, payload 01..06; bad_lo flips bits of the CRC low byte.
  task automatic pkt6(input string tg, input int gap, input logic [7:0] bad_lo, input logic exp_err);
    logic [15:0] c;
    c = crc_ref(64'h0000_0605_0403_0201, 6);
    cyc(1'b1, 1'b1, 32'h3900066A);
    chk({tg, "_hdr_pulses"}, {sp_vld, lp_vld, ecc_err, pkt_abort}, 32'h0);
    chk({tg, "_hdr_fields"}, {lp_vc, lp_dt, lp_wc}, {2'd1, 6'h2A, 16'd6});
    idle(gap);
    if (gap > 0) chk({tg, "_gap_vld"}, lp_vld, 32'h0);
    cyc(1'b1, 1'b0, 32'h04030201);
    chk({tg, "_w1_ctl"}, {lp_vld, lp_sof, lp_eof, lp_be}, {1'b1, 1'b1, 1'b0, 4'hF});
    chk({tg, "_w1_data"}, lp_data, 32'h04030201);
    idle(gap);
    cyc(1'b1, 1'b0, {c[15:8], c[7:0] ^ bad_lo, 16'h0605});
    chk({tg, "_w2_ctl"}, {lp_vld, lp_sof, lp_eof, lp_be}, {1'b1, 1'b0, 1'b1, 4'h3});
    chk({tg, "_w2_data"}, lp_data[15:0], 32'h0605);
    chk({tg, "_crc_err"}, crc_err, {31'd0, exp_err});
    idle(1);
    chk({tg, "_after"}, {crc_err, lp_vld, pkt_abort}, 32'h0);
  endtask

  initial begin
    logic [15:0] c4;
    c4 = crc_ref(64'h0000_0000_0403_0201, 4);
    reset = 1'b1; merging_valid = 1'b0; pkt_sof = 1'b0; merging_dat = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pulses", {sp_vld, lp_vld, lp_sof, lp_eof, ecc_err, crc_err, pkt_abort}, 32'h0);
    chk("reset_fields", {sp_vc, sp_dt, sp_data, lp_vc, lp_dt}, 32'h0);
    chk("reset_data", {lp_wc, lp_be}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Short FS packet, WC field 0x1234, ECC 0x01.
    cyc(1'b1, 1'b1, 32'h01123400);
    chk("fs_sp", {sp_vld, sp_vc, sp_dt, sp_data}, {1'b1, 2'd0, 6'h00, 16'h1234});
    chk("fs_no_lp", {lp_vld, ecc_err, pkt_abort}, 32'h0);
    idle(1);
    chk("fs_pulse_once", sp_vld, 32'h0);

    // Stray valid word in IDLE is ignored.
    cyc(1'b1, 1'b0, 32'hDEADBEEF);
    chk("idle_ignore", {lp_vld, sp_vld}, 32'h0);

    pkt6("raw8_good", 0, 8'h00, 1'b0);
    pkt6("raw8_badcrc", 0, 8'h01, 1'b1);

    // WC=4: footer arrives in the following word, low byte corrupted.
    cyc(1'b1, 1'b1, 32'h2500046A);
    chk("wc4_hdr", lp_wc, 32'd4);
    cyc(1'b1, 1'b0, 32'h04030201);
    chk("wc4_w1", {lp_vld, lp_sof, lp_eof, lp_be, crc_err}, {1'b1, 1'b1, 1'b1, 4'hF, 1'b0});
    cyc(1'b1, 1'b0, {16'hBEEF, c4[15:8], c4[7:0] ^ 8'h01});
    chk("wc4_crc_err", {crc_err, lp_vld}, {1'b1, 1'b0});
    idle(1);
    chk("wc4_crc_once", crc_err, 32'h0);

    // Header with one ECC bit flipped (WC=8, good ECC is 0x23).
    cyc(1'b1, 1'b1, 32'h2200086A);
    chk("ecc_err", {ecc_err, lp_vld, sp_vld}, {1'b1, 1'b0, 1'b0});
    chk("ecc_hold_wc", lp_wc, 32'd4);
    cyc(1'b1, 1'b0, 32'h04030201);
    chk("ecc_discard", {lp_vld, ecc_err}, 32'h0);
    cyc(1'b1, 1'b0, 32'h08070605);
    chk("ecc_discard2", lp_vld, 32'h0);
    pkt6("after_ecc", 0, 8'h00, 1'b0);

    // WC=8 cut short by a new (short) header.
    cyc(1'b1, 1'b1, 32'h2300086A);
    cyc(1'b1, 1'b0, 32'h04030201);
    chk("abort_w1", {lp_vld, lp_sof, lp_eof}, {1'b1, 1'b1, 1'b0});
    cyc(1'b1, 1'b1, 32'h01123400);
    chk("abort_pulse", {pkt_abort, lp_eof, lp_vld, sp_vld}, {1'b1, 1'b0, 1'b0, 1'b1});
    chk("abort_sp_data", sp_data, 32'h1234);
    pkt6("after_abort", 0, 8'h00, 1'b0);

    // WC=0 long packet: footer must equal the init value.
    cyc(1'b1, 1'b1, 32'h0600006A);
    chk("wc0_hdr", {lp_wc, lp_vld}, 32'h0);
    cyc(1'b1, 1'b0, 32'h0000FFFF);
    chk("wc0_good", {crc_err, lp_vld}, 32'h0);
    cyc(1'b1, 1'b1, 32'h0600006A);
    cyc(1'b1, 1'b0, 32'h0000FFFE);
    chk("wc0_bad", crc_err, 32'h1);

    pkt6("lane1", 3, 8'h00, 1'b0);

    // Idle timeout mid-payload.
    cyc(1'b1, 1'b1, 32'h2300086A);
    cyc(1'b1, 1'b0, 32'h04030201);
    idle(63);
    chk("tmo_63", pkt_abort, 32'h0);
    idle(1);
    chk("tmo_64", {pkt_abort, lp_vld, lp_eof}, {1'b1, 1'b0, 1'b0});
    cyc(1'b1, 1'b0, 32'h08070605);
    chk("tmo_idle", lp_vld, 32'h0);
    pkt6("after_tmo", 0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
